quad_input_conditioner: RTL and testbench

Front-end conditioner for the wheel quadrature encoder. It synchronizes the raw A/B pins, debounces each channel with a stable-count filter, and tracks the Gray-code phase. It outputs clean A/B levels, one-cycle step strobes with direction, and an illegal-transition indication. It sits directly upstream of the wheel interface control unit, which consumes the clean channels.

---
 rtl/quad_input_conditioner.sv | 138 +++++++++++++
 tb/tb_quad_input_conditioner.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/quad_input_conditioner.sv
// quad_input_conditioner: synchronize, debounce and phase-track a quadrature encoder (A/B) into clean levels and step strobes
//
// Ports:
//   clk, reset (async, active-high)
//   a_raw_i, b_raw_i : asynchronous encoder pins
//   err_clr_i        : synchronous clear of err_flag_o
//   a_clean_o, b_clean_o : debounced channel levels
//   step_valid_o / step_dir_o : one-cycle step strobe, direction (1 = CW), direction held between steps
//   illegal_o        : one-cycle strobe on a two-bit phase jump
//   err_flag_o       : sticky illegal indication
//   ready_o          : settle period after reset has ended
//
// Build option: define QIC_ILLEGAL_DETECT_EN to enable illegal_o / err_flag_o / err_clr_i.
// Without it a two-bit jump silently resynchronizes the phase tracker.
module quad_input_conditioner #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 16,
    parameter int CNT_W         = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic a_raw_i,
    input  logic b_raw_i,
    input  logic err_clr_i,
    output logic a_clean_o,
    output logic b_clean_o,
    output logic step_valid_o,
    output logic step_dir_o,
    output logic illegal_o,
    output logic err_flag_o,
    output logic ready_o
);
    localparam int SETTLE = SYNC_STAGES + STABLE_CYCLES + 1;
    localparam int SET_W  = $clog2(SETTLE + 1);

    // Low two bits of each phase state are the {A,B} levels it represents.
    typedef enum logic [2:0] {
        S00  = 3'b000,
        S01  = 3'b001,
        S10  = 3'b010,
        S11  = 3'b011,
        INIT = 3'b100
    } state_e;

    logic [1:0] raw, clean, cur, diff;
    logic [SET_W-1:0] settle_q, settle_d;
    logic ready_q, ready_d;
    state_e state_q, state_d;
    logic step_valid_q, step_valid_d, step_dir_q, step_dir_d;
    logic illegal_q, illegal_d, err_q, err_d, jump;

    assign raw = {a_raw_i, b_raw_i};

    for (genvar c = 0; c < 2; c++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q, sync_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic clean_q, clean_d, mism, hit;
        assign sync_d  = {sync_q[SYNC_STAGES-2:0], raw[c]};
        assign mism    = sync_q[SYNC_STAGES-1] ^ clean_q;
        // The toggle edge is the STABLE_CYCLES-th consecutive mismatching sample.
        assign hit     = mism & (cnt_q == CNT_W'(STABLE_CYCLES - 1));
        assign cnt_d   = (mism & ~hit) ? cnt_q + 1'b1 : '0;
        assign clean_d = clean_q ^ hit;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sync_q  <= '0;
                cnt_q   <= '0;
                clean_q <= 1'b0;
            end else begin
                sync_q  <= sync_d;
                cnt_q   <= cnt_d;
                clean_q <= clean_d;
            end
        end
        assign clean[c] = clean_q;
    end

    assign settle_d = ready_q ? settle_q : settle_q + 1'b1;
    assign ready_d  = ready_q | (settle_q == SET_W'(SETTLE - 1));

    assign cur  = state_q[1:0];
    assign diff = cur ^ clean;

    // INIT leaves only once ready is up, so strobes are inherently suppressed during settle.
    always_comb begin
        state_d      = state_q;
        step_valid_d = 1'b0;
        step_dir_d   = step_dir_q;
        jump         = 1'b0;
        if (state_q == INIT) begin
            state_d = ready_q ? state_e'({1'b0, clean}) : INIT;
        end else if (diff != 2'b00) begin
            state_d      = state_e'({1'b0, clean});
            jump         = (diff == 2'b11);
            step_valid_d = ~jump;
            // CW successor of {a,b} is {~b,a}: 00->10->11->01->00.
            step_dir_d   = jump ? step_dir_q : (clean == {~cur[0], cur[1]});
        end
    end

`ifdef QIC_ILLEGAL_DETECT_EN
    assign illegal_d = jump;
    assign err_d     = jump | (err_q & ~err_clr_i);
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr_i;
    assign illegal_d      = 1'b0;
    assign err_d          = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            settle_q     <= '0;
            ready_q      <= 1'b0;
            state_q      <= INIT;
            step_valid_q <= 1'b0;
            step_dir_q   <= 1'b0;
            illegal_q    <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            settle_q     <= settle_d;
            ready_q      <= ready_d;
            state_q      <= state_d;
            step_valid_q <= step_valid_d;
            step_dir_q   <= step_dir_d;
            illegal_q    <= illegal_d;
            err_q        <= err_d;
        end
    end

    assign a_clean_o    = clean[1];
    assign b_clean_o    = clean[0];
    assign step_valid_o = step_valid_q;
    assign step_dir_o   = step_dir_q;
    assign illegal_o    = illegal_q;
    assign err_flag_o   = err_q;
    assign ready_o      = ready_q;
endmodule

// File: tb/tb_quad_input_conditioner.sv
// tb_quad_input_conditioner: directed self-checking bench for quad_input_conditioner
module tb_quad_input_conditioner;
    logic clk = 1'b0;
    logic reset, a_raw, b_raw, err_clr;
    logic a_clean, b_clean, step_valid, step_dir, illegal, err_flag, ready;
    int n_chk = 0, n_fail = 0;
    int n_step = 0, n_cw = 0, n_ill = 0;

    quad_input_conditioner dut (
        .clk(clk), .reset(reset), .a_raw_i(a_raw), .b_raw_i(b_raw), .err_clr_i(err_clr),
        .a_clean_o(a_clean), .b_clean_o(b_clean), .step_valid_o(step_valid), .step_dir_o(step_dir),
        .illegal_o(illegal), .err_flag_o(err_flag), .ready_o(ready)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (step_valid === 1'b1) begin
            n_step = n_step + 1;
            if (step_dir === 1'b1) n_cw = n_cw + 1;
        end
        if (illegal === 1'b1) n_ill = n_ill + 1;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; a_raw = 1'b1; b_raw = 1'b1; err_clr = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_chk++;
        if ({a_clean, b_clean, step_valid, step_dir, illegal, err_flag, ready} !== 7'b0) begin
            n_fail++; $display("FAIL rst_async: got %b expected 0000000", {a_clean, b_clean, step_valid, step_dir, illegal, err_flag, ready});
        end
        tick(3);
        n_chk++;
        if ({a_clean, b_clean, step_valid, step_dir, illegal, err_flag, ready} !== 7'b0) begin
            n_fail++; $display("FAIL rst_hold: got %b expected 0000000", {a_clean, b_clean, step_valid, step_dir, illegal, err_flag, ready});
        end
        reset = 1'b0;
        tick(18);
        n_chk++;
        if (ready !== 1'b0) begin n_fail++; $display("FAIL settle_early: ready=%b expected 0", ready); end
        n_chk++;
        if ({a_clean, b_clean} !== 2'b11) begin n_fail++; $display("FAIL settle_clean: got %b expected 11", {a_clean, b_clean}); end
        tick(1);
        n_chk++;
        if (ready !== 1'b1) begin n_fail++; $display("FAIL settle_ready: ready=%b expected 1", ready); end
        tick(5);
        n_chk++;
        if (n_step != 0 || n_ill != 0) begin n_fail++; $display("FAIL settle_quiet: steps=%0d illegal=%0d expected 0 0", n_step, n_ill); end
    endtask

    task automatic test_init_state;
        a_raw = 1'b0;
        tick(18);
        n_chk++;
        if (step_valid !== 1'b0) begin n_fail++; $display("FAIL init_early: step_valid=%b expected 0", step_valid); end
        tick(1);
        n_chk++;
        if ({step_valid, step_dir} !== 2'b11) begin n_fail++; $display("FAIL init_s11: valid,dir=%b expected 11", {step_valid, step_dir}); end
        tick(21);
        b_raw = 1'b0;
        tick(40);
    endtask

    task automatic test_glitch;
        int base;
        logic seen;
        base = n_step;
        seen = 1'b0;
        a_raw = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            if (a_clean !== 1'b0) seen = 1'b1;
        end
        a_raw = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (a_clean !== 1'b0) seen = 1'b1;
        end
        n_chk++;
        if (seen !== 1'b0) begin n_fail++; $display("FAIL glitch_clean: a_clean rose=%b expected 0", seen); end
        n_chk++;
        if (n_step != base) begin n_fail++; $display("FAIL glitch_strobe: steps=%0d expected 0", n_step - base); end
    endtask

    task automatic test_cw;
        logic [1:0] seq [4];
        int base, bcw;
        seq[0] = 2'b10; seq[1] = 2'b11; seq[2] = 2'b01; seq[3] = 2'b00;
        base = n_step; bcw = n_cw;
        for (int i = 0; i < 4; i++) begin
            {a_raw, b_raw} = seq[i];
            tick(18);
            n_chk++;
            if (step_valid !== 1'b0) begin n_fail++; $display("FAIL cw_early[%0d]: step_valid=%b expected 0", i, step_valid); end
            tick(1);
            n_chk++;
            if ({step_valid, step_dir} !== 2'b11) begin n_fail++; $display("FAIL cw_step[%0d]: valid,dir=%b expected 11", i, {step_valid, step_dir}); end
            tick(21);
        end
        n_chk++;
        if (n_step - base != 4 || n_cw - bcw != 4) begin n_fail++; $display("FAIL cw_count: steps=%0d cw=%0d expected 4 4", n_step - base, n_cw - bcw); end
        n_chk++;
        if (step_dir !== 1'b1) begin n_fail++; $display("FAIL cw_dir_held: step_dir=%b expected 1", step_dir); end
    endtask

    task automatic test_ccw;
        logic [1:0] seq [4];
        int base, bcw;
        seq[0] = 2'b01; seq[1] = 2'b11; seq[2] = 2'b10; seq[3] = 2'b00;
        base = n_step; bcw = n_cw;
        for (int i = 0; i < 4; i++) begin
            {a_raw, b_raw} = seq[i];
            tick(18);
            n_chk++;
            if (step_valid !== 1'b0) begin n_fail++; $display("FAIL ccw_early[%0d]: step_valid=%b expected 0", i, step_valid); end
            tick(1);
            n_chk++;
            if ({step_valid, step_dir} !== 2'b10) begin n_fail++; $display("FAIL ccw_step[%0d]: valid,dir=%b expected 10", i, {step_valid, step_dir}); end
            tick(21);
        end
        n_chk++;
        if (n_step - base != 4 || n_cw != bcw) begin n_fail++; $display("FAIL ccw_count: steps=%0d cw=%0d expected 4 0", n_step - base, n_cw - bcw); end
        n_chk++;
        if (step_dir !== 1'b0) begin n_fail++; $display("FAIL ccw_dir_held: step_dir=%b expected 0", step_dir); end
    endtask

    task automatic test_illegal;
        int base;
        base = n_step;
        {a_raw, b_raw} = 2'b11;
        tick(18);
        n_chk++;
        if (illegal !== 1'b0) begin n_fail++; $display("FAIL ill_early: illegal=%b expected 0", illegal); end
        tick(1);
`ifdef QIC_ILLEGAL_DETECT_EN
        n_chk++;
        if ({illegal, err_flag, step_valid} !== 3'b110) begin n_fail++; $display("FAIL ill_strobe: ill,err,valid=%b expected 110", {illegal, err_flag, step_valid}); end
        tick(1);
        n_chk++;
        if ({illegal, err_flag} !== 2'b01) begin n_fail++; $display("FAIL ill_width: ill,err=%b expected 01", {illegal, err_flag}); end
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        n_chk++;
        if (err_flag !== 1'b0) begin n_fail++; $display("FAIL err_clr: err_flag=%b expected 0", err_flag); end
`else
        n_chk++;
        if ({illegal, err_flag, step_valid} !== 3'b000) begin n_fail++; $display("FAIL ill_disabled: ill,err,valid=%b expected 000", {illegal, err_flag, step_valid}); end
`endif
        tick(20);
        n_chk++;
        if (n_step != base) begin n_fail++; $display("FAIL ill_no_step: steps=%0d expected 0", n_step - base); end
        a_raw = 1'b0;
        tick(19);
        n_chk++;
        if ({step_valid, step_dir} !== 2'b11) begin n_fail++; $display("FAIL ill_state_s11: valid,dir=%b expected 11", {step_valid, step_dir}); end
        tick(21);
        {a_raw, b_raw} = 2'b10;
`ifdef QIC_ILLEGAL_DETECT_EN
        err_clr = 1'b1;
        tick(19);
        n_chk++;
        if ({illegal, err_flag, step_valid} !== 3'b110) begin n_fail++; $display("FAIL ill_set_wins: ill,err,valid=%b expected 110", {illegal, err_flag, step_valid}); end
        err_clr = 1'b0;
        tick(1);
        n_chk++;
        if (err_flag !== 1'b1) begin n_fail++; $display("FAIL err_hold: err_flag=%b expected 1", err_flag); end
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        n_chk++;
        if (err_flag !== 1'b0) begin n_fail++; $display("FAIL err_clr2: err_flag=%b expected 0", err_flag); end
`else
        err_clr = 1'b1;
        tick(19);
        err_clr = 1'b0;
        n_chk++;
        if ({illegal, err_flag, step_valid} !== 3'b000) begin n_fail++; $display("FAIL jump_silent: ill,err,valid=%b expected 000", {illegal, err_flag, step_valid}); end
`endif
        tick(20);
        a_raw = 1'b0;
        tick(19);
        n_chk++;
        if ({step_valid, step_dir} !== 2'b10) begin n_fail++; $display("FAIL resync_s10: valid,dir=%b expected 10", {step_valid, step_dir}); end
        tick(21);
    endtask

    task automatic test_reset_mid;
        int base, bi;
        a_raw = 1'b1;
        tick(10);
        reset = 1'b1;
        #1;
        n_chk++;
        if ({a_clean, b_clean, step_valid, step_dir, illegal, err_flag, ready} !== 7'b0) begin
            n_fail++; $display("FAIL mid_rst_async: got %b expected 0000000", {a_clean, b_clean, step_valid, step_dir, illegal, err_flag, ready});
        end
        tick(2);
        n_chk++;
        if (a_clean !== 1'b0) begin n_fail++; $display("FAIL mid_rst_clean: a_clean=%b expected 0", a_clean); end
        reset = 1'b0;
        base = n_step; bi = n_ill;
        tick(17);
        n_chk++;
        if ({a_clean, ready} !== 2'b00) begin n_fail++; $display("FAIL mid_discard: a_clean,ready=%b expected 00", {a_clean, ready}); end
        tick(1);
        n_chk++;
        if (a_clean !== 1'b1) begin n_fail++; $display("FAIL mid_clean: a_clean=%b expected 1", a_clean); end
        tick(1);
        n_chk++;
        if (ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: ready=%b expected 1", ready); end
        tick(5);
        n_chk++;
        if (n_step != base || n_ill != bi) begin n_fail++; $display("FAIL mid_no_strobe: steps=%0d illegal=%0d expected 0 0", n_step - base, n_ill - bi); end
    endtask

    initial begin
        test_reset;
        test_init_state;
        test_glitch;
        test_cw;
        test_ccw;
        test_illegal;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
